screen_compositor: RTL and testbench

SCREEN_COMPOSITOR -- requirements
Module: screen_compositor

---
 rtl/screen_compositor_if.sv | 60 ++++++
 rtl/screen_compositor.sv | 150 +++++++++++++++
 tb/tb_screen_compositor.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/screen_compositor_if.sv
`default_nettype none
// ============================================================================
// Module      : screen_compositor_if
// Description : Bundle of all non-clock signals of the screen compositor.
//               master : screen sources, request controller and font ROM side
//               slave  : the compositor itself
//   frame_start      one-cycle pulse at the start of each frame
//   req_valid        screen-change request strobe
//   req_screen       requested screen index
//   src_font_address per-screen font ROM address
//   src_Red/Green/Blue per-screen colour channels
//   font_address     address to the shared font ROM
//   font_data        combinational data from the shared font ROM
//   font_data_reg    registered font data broadcast to all screens
//   Red/Green/Blue   registered composited pixel colour
//   active_screen    screen currently displayed
//   busy             transition running or request pending
//   req_error        one-cycle pulse for an out-of-range request
// Revision    : 1.0 - initial release
// ============================================================================
interface screen_compositor_if #(
  parameter int NUM_SCREENS = 3,
  parameter int COLOR_W     = 4,
  parameter int FONT_ADDR_W = 11,
  parameter int FONT_DATA_W = 8
);
  localparam int c_sel_w = $clog2(NUM_SCREENS);

  logic                                    frame_start;
  logic                                    req_valid;
  logic [c_sel_w-1:0]                      req_screen;
  logic [NUM_SCREENS-1:0][FONT_ADDR_W-1:0] src_font_address;
  logic [NUM_SCREENS-1:0][COLOR_W-1:0]     src_Red;
  logic [NUM_SCREENS-1:0][COLOR_W-1:0]     src_Green;
  logic [NUM_SCREENS-1:0][COLOR_W-1:0]     src_Blue;
  logic [FONT_ADDR_W-1:0]                  font_address;
  logic [FONT_DATA_W-1:0]                  font_data;
  logic [FONT_DATA_W-1:0]                  font_data_reg;
  logic [COLOR_W-1:0]                      Red;
  logic [COLOR_W-1:0]                      Green;
  logic [COLOR_W-1:0]                      Blue;
  logic [c_sel_w-1:0]                      active_screen;
  logic                                    busy;
  logic                                    req_error;

  modport master (
    output frame_start, req_valid, req_screen, src_font_address,
           src_Red, src_Green, src_Blue, font_data,
    input  font_address, font_data_reg, Red, Green, Blue,
           active_screen, busy, req_error
  );

  modport slave (
    input  frame_start, req_valid, req_screen, src_font_address,
           src_Red, src_Green, src_Blue, font_data,
    output font_address, font_data_reg, Red, Green, Blue,
           active_screen, busy, req_error
  );
endinterface
`default_nettype wire

// File: rtl/screen_compositor.sv
`default_nettype none
// ============================================================================
// Module      : screen_compositor
// Description : Muxes NUM_SCREENS screen sources onto one pixel output and a
//               shared font ROM. Screen changes are requested by strobe and,
//               with FADE_EN=1, performed as a frame-paced fade-out / switch /
//               fade-in sequence; with FADE_EN=0 as a hard cut at frame start.
// Ports       : clk    pixel clock, rising edge
//               rst_n  synchronous active-low reset
//               bus    screen_compositor_if.slave (sources, requests, font
//                      ROM, composited colour and status)
// Revision    : 1.0 - initial release
// ============================================================================
module screen_compositor #(
  parameter int NUM_SCREENS  = 3,
  parameter int COLOR_W      = 4,
  parameter int FONT_ADDR_W  = 11,
  parameter int FONT_DATA_W  = 8,
  parameter int FADE_SHIFT   = 2,
  parameter int FADE_EN      = 1,
  parameter int RESET_SCREEN = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  screen_compositor_if.slave bus
);
  localparam int c_sel_w  = $clog2(NUM_SCREENS);
  localparam int c_lvl_w  = FADE_SHIFT + 1;
  localparam int c_prod_w = COLOR_W + FADE_SHIFT + 1;

  localparam logic [c_lvl_w-1:0] c_level_max  = c_lvl_w'(1 << FADE_SHIFT);
  localparam logic [c_lvl_w-1:0] c_level_one  = c_lvl_w'(1);
  localparam logic [c_lvl_w-1:0] c_level_top  = c_level_max - c_level_one;
  localparam logic [c_sel_w:0]   c_num_scr    = (c_sel_w + 1)'(NUM_SCREENS);
  localparam logic [c_sel_w-1:0] c_reset_scr  = c_sel_w'(RESET_SCREEN);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FADE_OUT = 2'd1,
    S_SWITCH   = 2'd2,
    S_FADE_IN  = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_lvl_w-1:0]   r_level;
  logic [c_sel_w-1:0]   r_active;
  logic [c_sel_w-1:0]   r_target;
  logic                 r_pend_valid;
  logic [c_sel_w-1:0]   r_pend_screen;
  logic [COLOR_W-1:0]   r_red;
  logic [COLOR_W-1:0]   r_green;
  logic [COLOR_W-1:0]   r_blue;
  logic [FONT_DATA_W-1:0] r_font_data;
  logic                 r_req_error;

  logic w_req_in_range;
  logic w_req_ignore;
  logic w_req_accept;

  // Product is wide enough that level = 2^FADE_SHIFT returns the input exactly.
  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                               input logic [c_lvl_w-1:0] l);
    logic [c_prod_w-1:0] p;
    p = c_prod_w'(c) * c_prod_w'(l);
    return COLOR_W'(p >> FADE_SHIFT);
  endfunction

  assign w_req_in_range = ({1'b0, bus.req_screen} < c_num_scr);
  // Re-requesting the shown screen is a no-op only when nothing else is queued
  // and no transition is running; otherwise it must overwrite the pending slot.
  assign w_req_ignore   = (r_state == S_IDLE) && !r_pend_valid &&
                          (bus.req_screen == r_active);
  assign w_req_accept   = bus.req_valid && w_req_in_range && !w_req_ignore;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_level       <= c_level_max;
      r_active      <= c_reset_scr;
      r_target      <= c_reset_scr;
      r_pend_valid  <= 1'b0;
      r_pend_screen <= c_reset_scr;
      r_red         <= '0;
      r_green       <= '0;
      r_blue        <= '0;
      r_font_data   <= '0;
      r_req_error   <= 1'b0;
    end else begin
      r_font_data <= bus.font_data;
      r_red       <= scale(bus.src_Red[r_active],   r_level);
      r_green     <= scale(bus.src_Green[r_active], r_level);
      r_blue      <= scale(bus.src_Blue[r_active],  r_level);
      r_req_error <= bus.req_valid && !w_req_in_range;

      case (r_state)
        S_IDLE: begin
          // The pending request is moved into r_target when a fade starts, so
          // the slot is free to collect requests made during the transition.
          if (bus.frame_start && r_pend_valid) begin
            r_pend_valid <= 1'b0;
            if (FADE_EN != 0) begin
              r_target <= r_pend_screen;
              r_level  <= c_level_top;
              r_state  <= (c_level_top == '0) ? S_SWITCH : S_FADE_OUT;
            end else begin
              r_active <= r_pend_screen;
            end
          end
        end
        S_FADE_OUT: begin
          if (bus.frame_start) begin
            r_level <= r_level - c_level_one;
            if (r_level == c_level_one) begin
              r_state <= S_SWITCH;
            end
          end
        end
        S_SWITCH: begin
          r_active <= r_target;
          r_state  <= S_FADE_IN;
        end
        S_FADE_IN: begin
          if (bus.frame_start) begin
            r_level <= r_level + c_level_one;
            if (r_level == c_level_top) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A new request takes precedence over the slot being emptied this cycle.
      if (w_req_accept) begin
        r_pend_valid  <= 1'b1;
        r_pend_screen <= bus.req_screen;
      end
    end
  end

  assign bus.font_address  = bus.src_font_address[r_active];
  assign bus.font_data_reg = r_font_data;
  assign bus.Red           = r_red;
  assign bus.Green         = r_green;
  assign bus.Blue          = r_blue;
  assign bus.active_screen = r_active;
  assign bus.busy          = (r_state != S_IDLE) || r_pend_valid;
  assign bus.req_error     = r_req_error;
endmodule
`default_nettype wire

// File: tb/tb_screen_compositor.sv
`default_nettype none
// ============================================================================
// Module      : tb_screen_compositor
// Description : Scoreboard bench for screen_compositor. Two instances share
//               the stimulus: u_fade (FADE_EN=1) and u_cut (FADE_EN=0).
//               Stimulus pushes hand-computed expectations tagged with the
//               cycle they apply to; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_screen_compositor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    screen_compositor_if bus1 ();
    screen_compositor_if bus2 ();

    screen_compositor #(.FADE_EN(1)) u_fade (.clk(clk), .rst_n(rst_n), .bus(bus1));
    screen_compositor #(.FADE_EN(0)) u_cut  (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // Font ROM model
    assign bus1.font_data = bus1.font_address[7:0] ^ 8'h5A;
    assign bus2.font_data = bus2.font_address[7:0] ^ 8'h5A;

    localparam int c_k_red = 0, c_k_green = 1, c_k_blue = 2, c_k_act = 3,
                   c_k_busy = 4, c_k_err = 5, c_k_faddr = 6, c_k_fdr = 7,
                   c_k_red2 = 8, c_k_act2 = 9;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] v;
        string       name;
    } exp_t;

    exp_t sb[$];

    function automatic logic [15:0] actual(input int kind);
        case (kind)
            c_k_red:   return 16'(bus1.Red);
            c_k_green: return 16'(bus1.Green);
            c_k_blue:  return 16'(bus1.Blue);
            c_k_act:   return 16'(bus1.active_screen);
            c_k_busy:  return 16'(bus1.busy);
            c_k_err:   return 16'(bus1.req_error);
            c_k_faddr: return 16'(bus1.font_address);
            c_k_fdr:   return 16'(bus1.font_data_reg);
            c_k_red2:  return 16'(bus2.Red);
            c_k_act2:  return 16'(bus2.active_screen);
            default:   return 16'hDEAD;
        endcase
    endfunction

    // Monitor
    exp_t        m_e;
    logic [15:0] m_a;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            m_e = sb.pop_front();
            m_a = actual(m_e.kind);
            n_checks++;
            if (m_e.cyc != cyc || m_a !== m_e.v) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                         m_e.name, m_a, m_e.v, m_e.cyc);
            end
        end
    end

    // Expectation for the state visible in the current cycle.
    task automatic chk(input int kind, input logic [15:0] v, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.v    = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick(input logic fs, input logic rv, input logic [1:0] rs);
        @(posedge clk);
        #1;
        bus1.frame_start = fs; bus1.req_valid = rv; bus1.req_screen = rs;
        bus2.frame_start = fs; bus2.req_valid = rv; bus2.req_screen = rs;
    endtask

    // One frame pulse, then one more cycle so the new level reaches the outputs.
    task automatic frame_step();
        tick(1'b1, 1'b0, 2'd0);
        tick(1'b0, 1'b0, 2'd0);
        tick(1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        bus1.src_Red   = {4'h8, 4'h5, 4'hF};
        bus1.src_Green = {4'hC, 4'h3, 4'h8};
        bus1.src_Blue  = {4'h7, 4'hA, 4'h1};
        bus1.src_font_address = {11'h3A2, 11'h211, 11'h100};
        bus2.src_Red   = bus1.src_Red;
        bus2.src_Green = bus1.src_Green;
        bus2.src_Blue  = bus1.src_Blue;
        bus2.src_font_address = bus1.src_font_address;
        bus1.frame_start = 1'b0; bus1.req_valid = 1'b0; bus1.req_screen = 2'd0;
        bus2.frame_start = 1'b0; bus2.req_valid = 1'b0; bus2.req_screen = 2'd0;

        // Reset state
        repeat (3) tick(1'b0, 1'b0, 2'd0);
        chk(c_k_red, 16'h0, "rst_red");
        chk(c_k_act, 16'h0, "rst_active");
        chk(c_k_busy, 16'h0, "rst_busy");
        chk(c_k_err, 16'h0, "rst_err");
        chk(c_k_fdr, 16'h0, "rst_fdr");
        rst_n = 1'b1;

        // Full intensity on screen 0
        tick(1'b1, 1'b0, 2'd0);
        chk(c_k_red, 16'hF, "s0_red");
        chk(c_k_green, 16'h8, "s0_green");
        chk(c_k_blue, 16'h1, "s0_blue");
        chk(c_k_faddr, 16'h100, "s0_faddr");
        chk(c_k_fdr, 16'h5A, "s0_fdr");
        chk(c_k_red2, 16'hF, "cut_s0_red");
        tick(1'b0, 1'b0, 2'd0);
        chk(c_k_red, 16'hF, "s0_red_frame");
        chk(c_k_busy, 16'h0, "s0_busy");

        // Out-of-range request
        tick(1'b0, 1'b1, 2'd3);
        tick(1'b0, 1'b0, 2'd0);
        chk(c_k_err, 16'h1, "oor_err_pulse");
        chk(c_k_busy, 16'h0, "oor_busy");
        chk(c_k_act, 16'h0, "oor_active");
        tick(1'b0, 1'b0, 2'd0);
        chk(c_k_err, 16'h0, "oor_err_end");

        // Request for the screen already shown is ignored
        tick(1'b0, 1'b1, 2'd0);
        tick(1'b0, 1'b0, 2'd0);
        chk(c_k_busy, 16'h0, "same_ignored");

        // Fade 0 -> 2
        tick(1'b0, 1'b1, 2'd2);
        tick(1'b0, 1'b0, 2'd0);
        chk(c_k_busy, 16'h1, "req2_busy");
        chk(c_k_red, 16'hF, "req2_red_full");
        tick(1'b1, 1'b0, 2'd0);
        tick(1'b0, 1'b0, 2'd0);
        chk(c_k_act2, 16'h2, "cut_act_2");
        chk(c_k_red2, 16'hF, "cut_red_old");
        tick(1'b0, 1'b0, 2'd0);
        chk(c_k_red, 16'hB, "fo_l3");
        chk(c_k_act, 16'h0, "fo_active0");
        chk(c_k_red2, 16'h8, "cut_red_s2");
        frame_step(); chk(c_k_red, 16'h7, "fo_l2");
        frame_step(); chk(c_k_red, 16'h3, "fo_l1");
        frame_step();
        chk(c_k_red, 16'h0, "sw_red0");
        chk(c_k_act, 16'h2, "sw_active2");
        chk(c_k_faddr, 16'h3A2, "sw_faddr");
        chk(c_k_busy, 16'h1, "sw_busy");
        frame_step(); chk(c_k_red, 16'h2, "fi_l1");
        frame_step(); chk(c_k_red, 16'h4, "fi_l2"); chk(c_k_green, 16'h6, "fi_l2_green");
        frame_step(); chk(c_k_red, 16'h6, "fi_l3");
        frame_step();
        chk(c_k_red, 16'h8, "fi_l4");
        chk(c_k_busy, 16'h0, "fade_done_busy");
        chk(c_k_fdr, 16'hF8, "s2_fdr");

        // Request together with frame_start is latched only
        tick(1'b1, 1'b1, 2'd1);
        tick(1'b0, 1'b0, 2'd0);
        chk(c_k_busy, 16'h1, "coinc_busy");
        tick(1'b0, 1'b0, 2'd0);
        chk(c_k_red, 16'h8, "coinc_no_fade");
        chk(c_k_act, 16'h2, "coinc_active");

        // Fade 2 -> 1 with requests 0 then 1 during FADE_OUT (last wins)
        tick(1'b1, 1'b0, 2'd0);
        tick(1'b0, 1'b0, 2'd0);
        chk(c_k_act2, 16'h1, "cut_act_1");
        tick(1'b0, 1'b0, 2'd0);
        chk(c_k_red, 16'h6, "fo2_l3");
        chk(c_k_red2, 16'h5, "cut_red_unscaled");
        tick(1'b0, 1'b1, 2'd0);
        tick(1'b0, 1'b1, 2'd1);
        tick(1'b0, 1'b0, 2'd0);
        chk(c_k_busy, 16'h1, "fo2_busy");
        frame_step(); chk(c_k_red, 16'h4, "fo2_l2");
        frame_step(); chk(c_k_red, 16'h2, "fo2_l1");
        frame_step();
        chk(c_k_act, 16'h1, "sw2_active1");
        chk(c_k_faddr, 16'h211, "sw2_faddr");
        frame_step(); chk(c_k_red, 16'h1, "fi2_l1");
        frame_step(); chk(c_k_red, 16'h2, "fi2_l2");
        frame_step(); chk(c_k_red, 16'h3, "fi2_l3");
        frame_step();
        chk(c_k_red, 16'h5, "fi2_l4");
        chk(c_k_busy, 16'h1, "second_pending");

        // Second full transition 1 -> 1
        frame_step(); chk(c_k_red, 16'h3, "fo3_l3");
        repeat (6) frame_step();
        frame_step();
        chk(c_k_red, 16'h5, "fi3_l4");
        chk(c_k_green, 16'h3, "fi3_green");
        chk(c_k_blue, 16'hA, "fi3_blue");
        chk(c_k_act, 16'h1, "final_active1");
        chk(c_k_busy, 16'h0, "final_busy");
        chk(c_k_fdr, 16'h4B, "s1_fdr");

        // Reset during FADE_IN with a request pending
        tick(1'b0, 1'b1, 2'd2);
        tick(1'b0, 1'b0, 2'd0);
        repeat (3) frame_step();
        frame_step();
        chk(c_k_act, 16'h2, "sw4_active2");
        frame_step();
        chk(c_k_red, 16'h2, "fi4_l1");
        tick(1'b0, 1'b1, 2'd1);
        tick(1'b0, 1'b0, 2'd0);
        chk(c_k_busy, 16'h1, "fi4_busy");
        rst_n = 1'b0;
        tick(1'b0, 1'b0, 2'd0);
        chk(c_k_act, 16'h0, "midrst_active");
        chk(c_k_busy, 16'h0, "midrst_busy");
        chk(c_k_red, 16'h0, "midrst_red");
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 2'd0);
        chk(c_k_red, 16'hF, "postrst_full");
        frame_step();
        chk(c_k_red, 16'hF, "postrst_no_fade");
        chk(c_k_busy, 16'h0, "postrst_busy");
        chk(c_k_act, 16'h0, "postrst_active");

        repeat (3) tick(1'b0, 1'b0, 2'd0);

        n_checks++;
        if (bus1.active_screen !== 2'd0) begin
            n_fail++;
            $display("FAIL end_active: got 0x%0h, expected 0x0", bus1.active_screen);
        end
        n_checks++;
        if (bus1.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL end_busy: got 0x%0h, expected 0x0", bus1.busy);
        end
        n_checks++;
        if (bus2.Red !== 4'hF) begin
            n_fail++;
            $display("FAIL end_cut_red: got 0x%0h, expected 0xf", bus2.Red);
        end

        while (sb.size() > 0) begin
            m_e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: never checked, expected 0x%0h", m_e.name, m_e.v);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
